cv32e40p_alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `cv32e40p_alu` instance between `NUM_REQ` requesters. Examples of requesters are the main EX stage, a debug/trace unit and a test port. Each request is accepted with a valid/ready handshake and latched. The arbiter then drives the ALU until its `ready_o` indicates completion, including multi-cycle division. It returns the result to the granted requester through a registered response handshake. The block sits directly in front of the ALU's input/output signal set.

---
 rtl/cv32e40p_alu_arbiter.sv | 128 ++++++++++++
 tb/tb_cv32e40p_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_alu_arbiter.sv
// rtl/cv32e40p_alu_arbiter.sv - round-robin arbiter/sequencer sharing one ALU between requesters
module cv32e40p_alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int OP_W    = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0][OP_W-1:0]   req_operator_i,
    input  logic [NUM_REQ-1:0][31:0]       req_operand_a_i,
    input  logic [NUM_REQ-1:0][31:0]       req_operand_b_i,
    input  logic [NUM_REQ-1:0][31:0]       req_operand_c_i,
    input  logic [NUM_REQ-1:0][1:0]        req_vector_mode_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [31:0]                    rsp_result_o,
    output logic                           rsp_cmp_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic                           alu_enable_o,
    output logic                           alu_ex_ready_o,
    output logic [OP_W-1:0]                alu_operator_o,
    output logic [31:0]                    alu_operand_a_o,
    output logic [31:0]                    alu_operand_b_o,
    output logic [31:0]                    alu_operand_c_o,
    output logic [1:0]                     alu_vector_mode_o,
    input  logic [31:0]                    alu_result_i,
    input  logic                           alu_cmp_i,
    input  logic                           alu_ready_i
);
    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    gnt_q;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_found;
    logic [IDX_W:0]      scan_idx;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [31:0]         rsp_result_q;
    logic                rsp_cmp_q;
    logic [OP_W-1:0]     op_q;
    logic [31:0]         opa_q;
    logic [31:0]         opb_q;
    logic [31:0]         opc_q;
    logic [1:0]          vm_q;

    // Search ptr, ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid_i[scan_idx[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign req_ready_o = (state == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_cmp_q    <= 1'b0;
            op_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            vm_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q <= gnt_idx;
                        op_q  <= req_operator_i[gnt_idx];
                        opa_q <= req_operand_a_i[gnt_idx];
                        opb_q <= req_operand_b_i[gnt_idx];
                        opc_q <= req_operand_c_i[gnt_idx];
                        vm_q  <= req_vector_mode_i[gnt_idx];
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (alu_ready_i) begin
                        rsp_result_q <= alu_result_i;
                        rsp_cmp_q    <= alu_cmp_i;
                        rsp_valid_q  <= NUM_REQ'(1) << gnt_q;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted requester's ready completes the response.
                    if (rsp_ready_i[gnt_q]) begin
                        rsp_valid_q <= '0;
                        ptr         <= (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_result_o      = rsp_result_q;
    assign rsp_cmp_o         = rsp_cmp_q;
    assign alu_enable_o      = (state == BUSY);
    assign alu_ex_ready_o    = (state == BUSY);
    assign alu_operator_o    = op_q;
    assign alu_operand_a_o   = opa_q;
    assign alu_operand_b_o   = opb_q;
    assign alu_operand_c_o   = opc_q;
    assign alu_vector_mode_o = vm_q;

endmodule

// File: tb/tb_cv32e40p_alu_arbiter.sv
// tb/tb_cv32e40p_alu_arbiter.sv - directed and randomized checks of cv32e40p_alu_arbiter
module tb_cv32e40p_alu_arbiter;
    localparam int N = 3;
    localparam logic [6:0] OP_ADD = 7'b0011000;
    localparam logic [6:0] OP_SUB = 7'b0011001;
    localparam logic [6:0] OP_DIV = 7'b0110001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid_i = '0;
    logic [N-1:0]     req_ready_o;
    logic [N-1:0][6:0]  req_operator_i = '0;
    logic [N-1:0][31:0] req_operand_a_i = '0;
    logic [N-1:0][31:0] req_operand_b_i = '0;
    logic [N-1:0][31:0] req_operand_c_i = '0;
    logic [N-1:0][1:0]  req_vector_mode_i = '0;
    logic [N-1:0]     rsp_valid_o;
    logic [31:0]      rsp_result_o;
    logic             rsp_cmp_o;
    logic [N-1:0]     rsp_ready_i = '0;
    logic             alu_enable_o, alu_ex_ready_o;
    logic [6:0]       alu_operator_o;
    logic [31:0]      alu_operand_a_o, alu_operand_b_o, alu_operand_c_o;
    logic [1:0]       alu_vector_mode_o;
    logic [31:0]      alu_result_i;
    logic             alu_cmp_i;
    logic             alu_ready_i;

    int tests = 0;
    int fails = 0;
    int div_lat = 0;
    int busy_cnt;

    cv32e40p_alu_arbiter #(.NUM_REQ(N), .OP_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operator_i(req_operator_i),
        .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i),
        .req_operand_c_i(req_operand_c_i), .req_vector_mode_i(req_vector_mode_i),
        .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o), .rsp_cmp_o(rsp_cmp_o),
        .rsp_ready_i(rsp_ready_i),
        .alu_enable_o(alu_enable_o), .alu_ex_ready_o(alu_ex_ready_o),
        .alu_operator_o(alu_operator_o),
        .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
        .alu_operand_c_o(alu_operand_c_o), .alu_vector_mode_o(alu_vector_mode_o),
        .alu_result_i(alu_result_i), .alu_cmp_i(alu_cmp_i), .alu_ready_i(alu_ready_i)
    );

    always #5 clk = ~clk;

    // ALU stand-in: divide stalls for div_lat cycles, everything else is single-cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (alu_enable_o && !alu_ready_i) busy_cnt <= busy_cnt + 1;
        else busy_cnt <= 0;
    end
    assign alu_ready_i = alu_enable_o && (alu_operator_o != OP_DIV || busy_cnt >= div_lat);
    assign alu_result_i = ref_result(alu_operator_o, alu_operand_a_o, alu_operand_b_o);
    assign alu_cmp_i = $signed(alu_operand_a_o) < $signed(alu_operand_b_o);

    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_ADD) return a + b;
        if (op == OP_SUB) return a - b;
        if (op == OP_DIV) return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        req_operator_i[r]  = op;
        req_operand_a_i[r] = a;
        req_operand_b_i[r] = b;
        req_operand_c_i[r] = 32'h0;
        req_vector_mode_i[r] = 2'b00;
    endtask

    task automatic wait_rsp;
        int cnt = 0;
        smp;
        while (rsp_valid_o == '0 && cnt < 200) begin
            nxt;
            smp;
            cnt++;
        end
    endtask

    initial begin
        logic [N-1:0] mask;
        logic [31:0]  hold_res;
        logic [31:0]  exp_res [N];
        logic         exp_cmp [N];
        int mptr, g, nstall;

        repeat (2) nxt;
        smp;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_enable", alu_enable_o, 0);
        chk("rst_ex_ready", alu_ex_ready_o, 0);
        chk("rst_result", rsp_result_o, 0);
        chk("rst_operator", alu_operator_o, 0);
        chk("rst_opa", alu_operand_a_o, 0);
        nxt;
        rst = 1'b0;

        // Single ADD, rsp_ready held high
        set_req(0, OP_ADD, 5, 7);
        req_valid_i = 3'b001;
        rsp_ready_i = 3'b111;
        smp; chk("add_T_ready", req_ready_o, 3'b001);
        nxt; req_valid_i = '0;
        smp; chk("add_T1_enable", alu_enable_o, 1);
        chk("add_T1_opa", alu_operand_a_o, 5);
        chk("add_T1_rspv", rsp_valid_o, 0);
        nxt;
        smp; chk("add_T2_rspv", rsp_valid_o, 3'b001);
        chk("add_T2_result", rsp_result_o, 12);
        nxt;
        smp; chk("add_T3_enable", alu_enable_o, 0);
        chk("add_T3_rspv", rsp_valid_o, 0);
        rsp_ready_i = '0;

        // Division on req1 with 34 stall cycles
        div_lat = 34;
        nxt;
        set_req(1, OP_DIV, 100, 7);
        req_valid_i = 3'b010;
        smp; chk("div_ready", req_ready_o, 3'b010);
        nxt; req_valid_i = '0;
        for (int i = 0; i < 35; i++) begin
            smp;
            chk("div_enable", alu_enable_o, 1);
            chk("div_opa", alu_operand_a_o, 100);
            chk("div_opb", alu_operand_b_o, 7);
            chk("div_rspv_low", rsp_valid_o, 0);
            nxt;
        end
        smp; chk("div_rspv", rsp_valid_o, 3'b010);
        chk("div_result", rsp_result_o, 14);
        rsp_ready_i = 3'b010;
        nxt; rsp_ready_i = '0;

        // Response backpressure on req0 with req1 pending; rsp_ready[1] must be ignored
        set_req(0, OP_ADD, 32'h1000, 32'h0234);
        req_valid_i = 3'b001;
        smp; chk("bp_ready0", req_ready_o, 3'b001);
        nxt;
        req_valid_i = 3'b010;
        set_req(1, OP_SUB, 50, 8);
        wait_rsp;
        chk("bp_rspv", rsp_valid_o, 3'b001);
        hold_res = rsp_result_o;
        chk("bp_result", hold_res, 32'h1234);
        rsp_ready_i = 3'b010;
        for (int i = 0; i < 5; i++) begin
            nxt; smp;
            chk("bp_hold_rspv", rsp_valid_o, 3'b001);
            chk("bp_hold_result", rsp_result_o, 32'h1234);
            chk("bp_hold_ready", req_ready_o, 0);
        end
        nxt; rsp_ready_i = 3'b001;
        nxt; rsp_ready_i = '0;
        smp; chk("bp_next_ready", req_ready_o, 3'b010);
        nxt; req_valid_i = '0;
        wait_rsp;
        chk("bp_r1_rspv", rsp_valid_o, 3'b010);
        chk("bp_r1_result", rsp_result_o, 42);
        rsp_ready_i = 3'b010;
        nxt; rsp_ready_i = '0;

        // Reset at BUSY cycle 10 of a division
        div_lat = 30;
        set_req(0, OP_DIV, 1000, 3);
        req_valid_i = 3'b001;
        nxt; req_valid_i = '0;
        repeat (9) nxt;
        smp; chk("rstdiv_busy", alu_enable_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstdiv_enable", alu_enable_o, 0);
        chk("rstdiv_ex_ready", alu_ex_ready_o, 0);
        chk("rstdiv_rspv", rsp_valid_o, 0);
        chk("rstdiv_opa", alu_operand_a_o, 0);
        chk("rstdiv_op", alu_operator_o, 0);
        nxt; nxt;
        rst = 1'b0;
        set_req(0, OP_SUB, 9, 4);
        req_valid_i = 3'b001;
        rsp_ready_i = 3'b001;
        smp; chk("sub_ready", req_ready_o, 3'b001);
        nxt; req_valid_i = '0;
        smp; chk("sub_rspv_T1", rsp_valid_o, 0);
        nxt;
        smp; chk("sub_rspv_T2", rsp_valid_o, 3'b001);
        chk("sub_result", rsp_result_o, 5);
        nxt; rsp_ready_i = '0;

        // Priority rotation: req2 alone, then req1+req2 with ptr wrapped to 0
        set_req(2, OP_ADD, 1, 1);
        req_valid_i = 3'b100;
        smp; chk("rot_ready2", req_ready_o, 3'b100);
        nxt; req_valid_i = '0;
        wait_rsp;
        chk("rot_rspv2", rsp_valid_o, 3'b100);
        rsp_ready_i = 3'b100;
        nxt; rsp_ready_i = '0;
        set_req(1, OP_ADD, 2, 2);
        req_valid_i = 3'b110;
        smp; chk("rot_ready1", req_ready_o, 3'b010);
        nxt; req_valid_i = '0;
        wait_rsp;
        rsp_ready_i = 3'b010;
        nxt; rsp_ready_i = '0;

        // Randomized transactions against the round-robin model
        mptr = 2;
        for (int n = 0; n < 60; n++) begin
            div_lat = $urandom_range(0, 6);
            mask = 3'($urandom_range(1, 7));
            for (int r = 0; r < N; r++) begin
                logic [6:0]  op;
                logic [31:0] a, b;
                case ($urandom_range(0, 2))
                    0: op = OP_ADD;
                    1: op = OP_SUB;
                    default: op = OP_DIV;
                endcase
                a = $urandom >> 1;
                b = 32'($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) b = $urandom;
                if (b == 0) b = 1;
                set_req(r, op, a, b);
                req_operand_c_i[r]   = $urandom;
                req_vector_mode_i[r] = 2'($urandom);
                case (op)
                    OP_ADD:  exp_res[r] = a + b;
                    OP_SUB:  exp_res[r] = a - b;
                    default: exp_res[r] = 32'($signed(a) / $signed(b));
                endcase
                exp_cmp[r] = $signed(a) < $signed(b);
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mask[(mptr + k) % N]) g = (mptr + k) % N;
            end
            req_valid_i = mask;
            smp; chk("rnd_ready", req_ready_o, 32'(1) << g);
            nxt; req_valid_i = '0;
            smp;
            chk("rnd_enable", alu_enable_o, 1);
            chk("rnd_opc", alu_operand_c_o, req_operand_c_i[g]);
            chk("rnd_vm", alu_vector_mode_o, 32'(req_vector_mode_i[g]));
            wait_rsp;
            chk("rnd_rspv", rsp_valid_o, 32'(1) << g);
            chk("rnd_result", rsp_result_o, exp_res[g]);
            chk("rnd_cmp", rsp_cmp_o, 32'(exp_cmp[g]));
            nstall = $urandom_range(0, 3);
            for (int s = 0; s < nstall; s++) begin
                rsp_ready_i = 3'($urandom) & ~(3'b001 << g);
                nxt; smp;
                chk("rnd_stall_rspv", rsp_valid_o, 32'(1) << g);
            end
            rsp_ready_i = 3'b001 << g;
            nxt; rsp_ready_i = '0;
            mptr = (g + 1) % N;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
